// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the ALU arbiter:
//   aluOp_e     - legal ALU control codes (AND, OR, ADD, SUB, SLT)
//   arbState_e  - arbiter FSM states
//   isLegalOp() - screens a 4-bit control code before it reaches the ALU
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } aluOp_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arbState_e;

    // Code put on aluCtrl whenever the ALU result is not wanted.
    localparam logic [3:0] ALU_CTRL_NOP = 4'b0000;

    function automatic logic isLegalOp(input logic [3:0] ctrl);
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// -----------------------------------------------------------------------------
// alu_arb_grant
// Combinational winner selection among NUM_REQ requesters.
// Build option: ALU_ARB_ROUND_ROBIN_EN
//   defined   - round robin, search starts at lastGrant_i+1 and wraps
//   undefined - fixed priority, lowest index wins (lastGrant_i ignored)
// Ports:
//   reqValid_i  [NUM_REQ]  request valid bits
//   lastGrant_i [IDX_W]    index of the previous winner
//   grantOh_o   [NUM_REQ]  one-hot winner (zero if nobody requests)
//   grantIdx_o  [IDX_W]    binary index of the winner
//   anyValid_o             at least one request pending
// -----------------------------------------------------------------------------
module alu_arb_grant #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] reqValid_i,
    input  logic [IDX_W-1:0]   lastGrant_i,
    output logic [NUM_REQ-1:0] grantOh_o,
    output logic [IDX_W-1:0]   grantIdx_o,
    output logic               anyValid_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    assign anyValid_o = |reqValid_i;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Walk the ring starting just after the last winner; first hit wins.
    always_comb begin
        grantOh_o  = '0;
        grantIdx_o = '0;
        found      = 1'b0;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(lastGrant_i) + i) % NUM_REQ);
            if (!found && reqValid_i[cand]) begin
                found            = 1'b1;
                grantIdx_o       = cand;
                grantOh_o[cand]  = 1'b1;
            end
        end
    end
`else
    // Fixed priority: lowest index wins, history plays no part.
    logic unusedLastGrant;
    assign unusedLastGrant = ^lastGrant_i;

    always_comb begin
        grantOh_o  = '0;
        grantIdx_o = '0;
        found      = 1'b0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'(i);
            if (!found && reqValid_i[cand]) begin
                found            = 1'b1;
                grantIdx_o       = cand;
                grantOh_o[cand]  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one external single-cycle ALU between NUM_REQ requesters.
// Each request runs accept -> execute -> respond; operands and result are
// registered on both sides of the ALU. Illegal control codes never reach the
// ALU: they produce result 0 with rspIllegal set.
// Build option: ALU_ARB_ROUND_ROBIN_EN (round robin vs fixed priority).
// Ports:
//   clk, rstN                      clock, async active-low reset
//   reqValid/reqReady  [NUM_REQ]   request handshake (reqReady one-hot or 0)
//   reqCtrl   [NUM_REQ][4]         ALU control code per requester
//   reqOp1/2  [NUM_REQ][DATA_W]    operands per requester
//   rspValid/rspReady  [NUM_REQ]   response handshake (rspValid one-hot or 0)
//   rspResult [DATA_W], rspIllegal shared response payload
//   aluCtrl, aluOp1, aluOp2        to the ALU (zero outside EXEC)
//   aluResult                      from the ALU
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic [NUM_REQ-1:0]             reqValid,
    output logic [NUM_REQ-1:0]             reqReady,
    input  logic [NUM_REQ-1:0][3:0]        reqCtrl,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] reqOp1,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] reqOp2,
    output logic [NUM_REQ-1:0]             rspValid,
    input  logic [NUM_REQ-1:0]             rspReady,
    output logic [DATA_W-1:0]              rspResult,
    output logic                           rspIllegal,
    output logic [3:0]                     aluCtrl,
    output logic [DATA_W-1:0]              aluOp1,
    output logic [DATA_W-1:0]              aluOp2,
    input  logic [DATA_W-1:0]              aluResult
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arbState_e          state_q;
    logic [IDX_W-1:0]   gnt_q;
    logic [3:0]         ctrl_q;
    logic [DATA_W-1:0]  op1_q;
    logic [DATA_W-1:0]  op2_q;
    logic [DATA_W-1:0]  result_q;
    logic               illegal_q;

    logic [NUM_REQ-1:0] grantOh;
    logic [IDX_W-1:0]   grantIdx;
    logic [IDX_W-1:0]   lastGrant;
    logic               anyValid;
    logic               rspDone;
    logic               accept;

    alu_arb_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_grant (
        .reqValid_i  (reqValid),
        .lastGrant_i (lastGrant),
        .grantOh_o   (grantOh),
        .grantIdx_o  (grantIdx),
        .anyValid_o  (anyValid)
    );

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Reset to the last index so requester 0 is first in line.
    logic [IDX_W-1:0] lastGrant_q;
    logic [IDX_W-1:0] lastGrant_d;

    assign lastGrant_d = accept ? grantIdx : lastGrant_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) lastGrant_q <= IDX_W'(NUM_REQ - 1);
        else       lastGrant_q <= lastGrant_d;
    end

    assign lastGrant = lastGrant_q;
`else
    assign lastGrant = '0;
`endif

    // A response is retired only by the owner's rspReady; a retiring RESP
    // cycle doubles as an accept cycle so back-to-back ops take 2 cycles.
    assign rspDone  = (state_q == RESP) && rspReady[gnt_q];
    assign accept   = anyValid && ((state_q == IDLE) || rspDone);
    assign reqReady = accept ? grantOh : '0;

    always_comb begin
        rspValid = '0;
        if (state_q == RESP) rspValid[gnt_q] = 1'b1;
    end

    // ALU inputs are live only in EXEC; an illegal code is replaced by NOP.
    assign aluCtrl = (state_q == EXEC && isLegalOp(ctrl_q)) ? ctrl_q : ALU_CTRL_NOP;
    assign aluOp1  = (state_q == EXEC) ? op1_q : '0;
    assign aluOp2  = (state_q == EXEC) ? op2_q : '0;

    assign rspResult  = result_q;
    assign rspIllegal = illegal_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ctrl_q    <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                gnt_q  <= grantIdx;
                ctrl_q <= reqCtrl[grantIdx];
                op1_q  <= reqOp1[grantIdx];
                op2_q  <= reqOp2[grantIdx];
            end
            case (state_q)
                IDLE: if (accept) state_q <= EXEC;
                EXEC: begin
                    if (isLegalOp(ctrl_q)) begin
                        result_q  <= aluResult;
                        illegal_q <= 1'b0;
                    end else begin
                        result_q  <= '0;
                        illegal_q <= 1'b1;
                    end
                    state_q <= RESP;
                end
                RESP: if (rspDone) state_q <= accept ? EXEC : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
